// File: rtl/regfile_psr_pkg.sv
// Shared ALU opcode encodings plus PSR bit positions and the per-opcode flag update mask.
package regfile_psr_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_CMP  = 4'h2,
      OP_CMPR = 4'h3,
      OP_AND  = 4'h4,
      OP_OR   = 4'h5,
      OP_XOR  = 4'h6,
      OP_NOT  = 4'h7,
      OP_LSH  = 4'h8,
      OP_RSH  = 4'h9,
      OP_ARSH = 4'hA
   } alu_op_e;

   localparam int unsigned PSR_F = 3;
   localparam int unsigned PSR_L = 2;
   localparam int unsigned PSR_N = 1;
   localparam int unsigned PSR_Z = 0;

   // Which PSR bits an opcode is allowed to overwrite; unlisted opcodes touch nothing.
   function automatic logic [3:0] psr_mask(input logic [3:0] op);
      logic [3:0] m;
      m = '0;
      case (op)
         OP_ADD, OP_SUB: begin
            m[PSR_F] = 1'b1;
            m[PSR_L] = 1'b1;
            m[PSR_N] = 1'b1;
            m[PSR_Z] = 1'b1;
         end
         OP_CMP, OP_CMPR: begin
            m[PSR_L] = 1'b1;
            m[PSR_N] = 1'b1;
            m[PSR_Z] = 1'b1;
         end
         OP_AND, OP_OR, OP_XOR, OP_NOT: begin
            m[PSR_N] = 1'b1;
            m[PSR_Z] = 1'b1;
         end
         OP_LSH, OP_RSH, OP_ARSH: begin
            m[PSR_Z] = 1'b1;
         end
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/regfile_psr_psr.sv
// Processor status register {F,L,N,Z}; only the bits selected by the opcode mask update.
module psr_reg
   import regfile_psr_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] op,
   input  logic       psr_en,
   input  logic [3:0] flags,
   output logic [3:0] psr
);

   logic [3:0] mask;

   always_comb begin
      mask = psr_mask(op);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         psr <= '0;
      end else if (psr_en) begin
         psr <= (psr & ~mask) | (flags & mask);
      end
   end

endmodule

// File: rtl/regfile_psr.sv
// 16x16 register file with two bypassed combinational read ports and a masked PSR.
module regfile_psr
   import regfile_psr_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  ra_addr,
   input  logic [3:0]  rb_addr,
   input  logic [3:0]  rd_addr,
   input  logic        wr_en,
   input  logic [15:0] wr_data,
   input  logic [3:0]  op,
   input  logic        psr_en,
   input  logic        flag_in,
   input  logic        low_in,
   input  logic        neg_in,
   input  logic        zero_in,
   output logic [15:0] a_out,
   output logic [15:0] b_out,
   output logic [3:0]  psr_out
);

   logic [15:0] regs [16];
   logic [3:0]  flags;

   always_ff @(posedge clk) begin
      if (reset) begin
         regs <= '{default: '0};
      end else if (wr_en) begin
         regs[rd_addr] <= wr_data;
      end
   end

   // Write-through: a read of the register being written sees the new value this cycle.
   always_comb begin
      a_out = regs[ra_addr];
      b_out = regs[rb_addr];
      if (wr_en && (ra_addr == rd_addr)) a_out = wr_data;
      if (wr_en && (rb_addr == rd_addr)) b_out = wr_data;
   end

   always_comb begin
      flags        = '0;
      flags[PSR_F] = flag_in;
      flags[PSR_L] = low_in;
      flags[PSR_N] = neg_in;
      flags[PSR_Z] = zero_in;
   end

   psr_reg u_psr (
      .clk    (clk),
      .reset  (reset),
      .op     (op),
      .psr_en (psr_en),
      .flags  (flags),
      .psr    (psr_out)
   );

endmodule

// File: doc/regfile_psr.md
REGFILE_PSR -- requirements
Module: regfile_psr

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 ra_addr  input  4  register index for the A read port.
REQ-005 rb_addr  input  4  register index for the B read port.
REQ-006 rd_addr  input  4  destination register index for write-back.
REQ-007 wr_en  input  1  write-back enable for wr_data into rd_addr.
REQ-008 wr_data  input  16  write-back value, normally the ALU result C.
REQ-009 op  input  4  ALU opcode of the instruction being retired; selects which PSR bits update.
REQ-010 psr_en  input  1  flag update enable.
REQ-011 flag_in, low_in, neg_in, zero_in  input  1 each  ALU Flag/Low/Negative/Zero outputs.
REQ-012 a_out  output  16  A operand, feeding the ALU A input.
REQ-013 b_out  output  16  B operand, feeding the ALU B input.
REQ-014 psr_out  output  4  current {F,L,N,Z}: bit3=F, bit2=L, bit1=N, bit0=Z.

Function
REQ-015 Storage SHALL be 16 registers of 16 bits (R0..R15); all 16 SHALL be writable.
REQ-016 When wr_en=1, wr_data SHALL be written to R[rd_addr] at the rising edge; when wr_en=0, no register SHALL change.
REQ-017 a_out and b_out SHALL be combinational reads of R[ra_addr] and R[rb_addr], with zero cycles of read latency.
REQ-018 Write-through bypass: when wr_en=1 and ra_addr==rd_addr, a_out SHALL equal wr_data in the same cycle; the same rule SHALL apply to b_out and rb_addr.
REQ-019 Both read ports MAY address the same register and SHALL then return identical values.
REQ-020 PSR bits SHALL update at the rising edge only when psr_en=1, and only for the bits selected by op.
REQ-021 ADD and SUB SHALL update F, L, N and Z.
REQ-022 CMP and CMPR SHALL update L, N and Z; F SHALL be held.
REQ-023 AND, OR, XOR and NOT SHALL update N and Z; F and L SHALL be held.
REQ-024 LSH, RSH and ARSH SHALL update Z only.
REQ-025 Any other op value SHALL leave the PSR unchanged, even when psr_en=1.
REQ-026 psr_out SHALL reflect the registered PSR only; there SHALL be no bypass of the flag inputs to psr_out.
REQ-027 Simultaneous wr_en and psr_en in one cycle SHALL both take effect independently.
REQ-028 An rd_addr of 15 SHALL behave like any other index; there SHALL be no address wrap or aliasing.

Reset
REQ-029 While reset=1 at a rising edge, all 16 registers and the PSR SHALL be cleared to 0; wr_en and psr_en SHALL be ignored in that cycle.
REQ-030 After reset, a_out and b_out SHALL read 16'h0000 (unless bypassed) and psr_out SHALL read 4'b0000.
REQ-031 Reset asserted mid-operation SHALL discard any write or flag update presented in that cycle.
REQ-032 The first write SHALL be accepted on the first edge at which reset=0.

Structure
REQ-033 The 4-bit ALU opcode constants (ADD, SUB, CMP, CMPR, AND, OR, XOR, NOT, LSH, RSH, ARSH) SHALL come from the team's shared opcode package/include, which is also used by the ALU; the PSR bit-position constants SHALL be added to that package.
REQ-034 The PSR and its per-opcode update mask SHALL be a sub-module named psr_reg; the register array and bypass logic SHALL stay in regfile_psr.

Verification
REQ-035 Reset then read: assert reset for one edge, set ra_addr=3 and rb_addr=15 -> a_out=0000, b_out=0000, psr_out=0000.
REQ-036 Write then read: wr_en=1, rd_addr=5, wr_data=BEEF; next cycle wr_en=0, ra_addr=5 -> a_out=BEEF.
REQ-037 Bypass: wr_en=1, rd_addr=7, wr_data=1234, ra_addr=7, rb_addr=7 in the same cycle -> a_out=b_out=1234 before the edge.
REQ-038 Masked flags:
- op=ADD, psr_en=1, F/L/N/Z in=1/1/1/1 -> psr_out=1111.
- then op=CMP with F/L/N/Z in=0/0/0/0 -> psr_out=1000.
- then op=LSH with zero_in=1 -> psr_out=1001.
REQ-039 Reset mid-write: reset=1 together with wr_en=1, rd_addr=2, wr_data=FFFF -> R2 reads 0000 afterward.
REQ-040 Disabled flags: psr_en=0 with op=SUB and all flag inputs=1 -> psr_out unchanged; op=4'hF with psr_en=1 -> psr_out unchanged.
